// File: rtl/pattern_delay_timer_if.sv
// Serial start/delay bus for pattern_delay_timer: stimulus inputs plus timer status.
// The abort signal exists only when PATTERN_DELAY_TIMER_ABORT_EN is defined.
interface pattern_delay_timer_if #(
  parameter int unsigned DELAY_W = 4
);
  logic               data;
  logic               ack;
`ifdef PATTERN_DELAY_TIMER_ABORT_EN
  logic               abort;
`endif
  logic [DELAY_W-1:0] count;
  logic               counting;
  logic               done;

`ifdef PATTERN_DELAY_TIMER_ABORT_EN
  modport master (output data, output ack, output abort,
                  input count, input counting, input done);
  modport slave  (input data, input ack, input abort,
                  output count, output counting, output done);
`else
  modport master (output data, output ack,
                  input count, input counting, input done);
  modport slave  (input data, input ack,
                  output count, output counting, output done);
`endif
endinterface

// File: rtl/pattern_delay_timer.sv
// Serial-start timer: detect start pattern, shift in a delay, count (delay+1) ticks, raise done until ack.
// Optional abort of LOAD/COUNT is enabled by defining PATTERN_DELAY_TIMER_ABORT_EN.
module pattern_delay_timer #(
  parameter int unsigned            PATTERN_W   = 4,
  parameter logic [PATTERN_W-1:0]   PATTERN     = 4'b1101,
  parameter int unsigned            DELAY_W     = 4,
  parameter int unsigned            TICK_CYCLES = 1000
) (
  input logic                  clk,
  input logic                  reset,
  pattern_delay_timer_if.slave bus
);
  localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int unsigned IDX_W  = (DELAY_W > 1) ? $clog2(DELAY_W) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DELAY_W - 1);

  typedef enum logic [1:0] {SEARCH, LOAD, COUNT, DONE} state_t;

  state_t               state;
  logic [PATTERN_W-1:0] shreg;
  logic [DELAY_W-1:0]   delay;
  logic [TICK_W-1:0]    tick;
  logic [IDX_W-1:0]     bit_idx;
  logic [DELAY_W-1:0]   count_q;
  logic                 counting_q;
  logic                 done_q;

  logic [PATTERN_W-1:0] pat_next;
  logic [DELAY_W-1:0]   delay_next;
  logic                 abort_hit;

  // Newest bit enters at the LSB; the match window includes the bit sampled this edge.
  assign pat_next   = PATTERN_W'({shreg, bus.data});
  assign delay_next = DELAY_W'({delay, bus.data});

`ifdef PATTERN_DELAY_TIMER_ABORT_EN
  assign abort_hit = bus.abort;
`else
  assign abort_hit = 1'b0;
`endif

  assign bus.count    = count_q;
  assign bus.counting = counting_q;
  assign bus.done     = done_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= SEARCH;
      shreg      <= '0;
      delay      <= '0;
      tick       <= '0;
      bit_idx    <= '0;
      count_q    <= '0;
      counting_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          shreg <= pat_next;
          if (pat_next == PATTERN) begin
            state   <= LOAD;
            bit_idx <= '0;
          end
        end

        LOAD: begin
          if (abort_hit) begin
            state <= SEARCH;
            shreg <= '0;
          end else begin
            delay   <= delay_next;
            bit_idx <= bit_idx + IDX_W'(1);
            if (bit_idx == IDX_LAST) begin
              state      <= COUNT;
              count_q    <= delay_next;
              tick       <= '0;
              counting_q <= 1'b1;
            end
          end
        end

        // count holds (remaining ticks - 1); the run ends on the last cycle of the zero tick.
        COUNT: begin
          if (abort_hit) begin
            state      <= SEARCH;
            shreg      <= '0;
            count_q    <= '0;
            counting_q <= 1'b0;
          end else if (tick == TICK_LAST) begin
            tick <= '0;
            if (count_q != '0) begin
              count_q <= count_q - DELAY_W'(1);
            end else begin
              state      <= DONE;
              counting_q <= 1'b0;
              done_q     <= 1'b1;
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end

        DONE: begin
          if (bus.ack) begin
            state  <= SEARCH;
            done_q <= 1'b0;
            shreg  <= '0;
          end
        end

        default: state <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_delay_timer.sv
// Randomised and directed bench for pattern_delay_timer against a cycle-count reference model.
// Abort scenarios are included when PATTERN_DELAY_TIMER_ABORT_EN is defined.
module tb_pattern_delay_timer;
  localparam int unsigned          PATTERN_W   = 4;
  localparam logic [PATTERN_W-1:0] PATTERN     = 4'b1101;
  localparam int unsigned          DELAY_W     = 4;
  localparam int unsigned          TICK_CYCLES = 10;
  localparam int                   MAX_RUN     = 400;

  localparam int P_SEARCH = 0;
  localparam int P_LOAD   = 1;
  localparam int P_COUNT  = 2;
  localparam int P_DONE   = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pattern_delay_timer_if #(.DELAY_W(DELAY_W)) bus ();

  pattern_delay_timer #(
    .PATTERN_W  (PATTERN_W),
    .PATTERN    (PATTERN),
    .DELAY_W    (DELAY_W),
    .TICK_CYCLES(TICK_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: bits seen since the last clear, delay being collected, cycles elapsed in the run.
  bit hist[$];
  int phase   = P_SEARCH;
  int nbits   = 0;
  int dly     = 0;
  int elapsed = 0;
  int cnt_log[MAX_RUN];
`ifdef PATTERN_DELAY_TIMER_ABORT_EN
  logic abort_drv = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    hist.delete();
    phase   = P_SEARCH;
    nbits   = 0;
    dly     = 0;
    elapsed = 0;
  endfunction

  function automatic bit window_matches();
    logic [PATTERN_W-1:0] pat;
    pat = PATTERN;
    if (hist.size() != int'(PATTERN_W)) return 1'b0;
    for (int i = 0; i < int'(PATTERN_W); i++)
      if (hist[i] != pat[int'(PATTERN_W) - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_update(input logic d, input logic a);
`ifdef PATTERN_DELAY_TIMER_ABORT_EN
    if ((phase == P_LOAD || phase == P_COUNT) && abort_drv) begin
      phase = P_SEARCH;
      hist.delete();
      return;
    end
`endif
    case (phase)
      P_SEARCH: begin
        hist.push_back(d);
        if (hist.size() > int'(PATTERN_W)) void'(hist.pop_front());
        if (window_matches()) begin
          phase = P_LOAD;
          nbits = 0;
          dly   = 0;
        end
      end
      P_LOAD: begin
        dly = dly * 2 + int'(d);
        nbits++;
        if (nbits == int'(DELAY_W)) begin
          phase   = P_COUNT;
          elapsed = 0;
        end
      end
      P_COUNT: begin
        elapsed++;
        if (elapsed == (dly + 1) * int'(TICK_CYCLES)) phase = P_DONE;
      end
      default: begin
        if (a) begin
          phase = P_SEARCH;
          hist.delete();
        end
      end
    endcase
  endfunction

  function automatic int exp_count();
    return (phase == P_COUNT) ? dly - elapsed / int'(TICK_CYCLES) : 0;
  endfunction

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("model_count",    int'(bus.count),    exp_count());
      chk("model_counting", int'(bus.counting), int'(phase == P_COUNT));
      chk("model_done",     int'(bus.done),     int'(phase == P_DONE));
    end
  end

  task automatic step(input logic d, input logic a);
    bus.data = d;
    bus.ack  = a;
`ifdef PATTERN_DELAY_TIMER_ABORT_EN
    bus.abort = abort_drv;
`endif
    @(posedge clk);
    model_update(d, a);
    @(negedge clk);
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Steps while counting is high; returns how many sampled cycles had counting=1.
  task automatic run_count(input int ack_at, output int ncyc, output logic done_seen);
    ncyc = 0;
    while (bus.counting && ncyc < MAX_RUN) begin
      cnt_log[ncyc] = int'(bus.count);
      step(1'($urandom_range(0, 1)), logic'(ncyc == ack_at));
      ncyc++;
    end
    done_seen = bus.done;
  endtask

  task automatic wait_count2();
    int w;
    w = 0;
    while (!(bus.counting && bus.count == DELAY_W'(2)) && w < 100) begin
      step(1'b0, 1'b0);
      w++;
    end
    chk("wait_count2", int'(bus.count), 2);
  endtask

  initial begin
    int   n;
    logic ds;
    bus.data = 1'b0;
    bus.ack  = 1'b0;
`ifdef PATTERN_DELAY_TIMER_ABORT_EN
    bus.abort = 1'b0;
`endif
    do_reset();
    chk("reset_count",    int'(bus.count),    0);
    chk("reset_counting", int'(bus.counting), 0);
    chk("reset_done",     int'(bus.done),     0);

    // Basic run: pattern then delay 0011
    feed(16'b1101_0011, 8);
    chk("basic_counting", int'(bus.counting), 1);
    chk("basic_count",    int'(bus.count),    3);
    run_count(-1, n, ds);
    chk("basic_len",  n, 40);
    chk("basic_done", int'(ds), 1);
    chk("basic_log0",  cnt_log[0],  3);
    chk("basic_log9",  cnt_log[9],  3);
    chk("basic_log10", cnt_log[10], 2);
    chk("basic_log29", cnt_log[29], 1);
    chk("basic_log39", cnt_log[39], 0);
    step(1'b0, 1'b1);
    chk("ack_clear", int'(bus.done), 0);

    // Overlapping match on bit 5, delay 0000
    feed(16'b11101, 5);
    feed(16'b000, 3);
    chk("ovl_not_yet", int'(bus.counting), 0);
    step(1'b0, 1'b0);
    chk("ovl_counting", int'(bus.counting), 1);
    chk("ovl_count",    int'(bus.count),    0);
    run_count(-1, n, ds);
    chk("ovl_len", n, 10);
    step(1'b0, 1'b1);

    // False start: match only on bit 8, delay 1111
    feed(16'b1100_1101, 8);
    feed(16'b1111, 4);
    chk("max_counting", int'(bus.counting), 1);
    chk("max_count",    int'(bus.count),    15);
    run_count(-1, n, ds);
    chk("max_len",  n, 160);
    chk("max_done", int'(ds), 1);

    // Handshake: done held 50 cycles while the pattern streams in
    for (int i = 0; i < 50; i++) step(logic'((i % 4) != 2), 1'b0);
    chk("hold_done", int'(bus.done), 1);
    step(1'b1, 1'b1);
    chk("hold_ack", int'(bus.done), 0);
    feed(16'b101_1101, 7);
    feed(16'b0001, 4);
    chk("post_ack_counting", int'(bus.counting), 1);
    chk("post_ack_count",    int'(bus.count),    1);
    run_count(5, n, ds);
    chk("ack_in_count_len",  n, 20);
    chk("ack_in_count_done", int'(ds), 1);
    step(1'b0, 1'b1);

    // Asynchronous reset mid-COUNT
    feed(16'b1101_0011, 8);
    wait_count2();
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("areset_count",    int'(bus.count),    0);
    chk("areset_counting", int'(bus.counting), 0);
    chk("areset_done",     int'(bus.done),     0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    feed(16'b1101_0001, 8);
    run_count(-1, n, ds);
    chk("areset_run_len", n, 20);
    step(1'b0, 1'b1);

`ifdef PATTERN_DELAY_TIMER_ABORT_EN
    feed(16'b1101_0011, 8);
    wait_count2();
    abort_drv = 1'b1;
    step(1'b0, 1'b0);
    abort_drv = 1'b0;
    chk("abort_counting", int'(bus.counting), 0);
    chk("abort_count",    int'(bus.count),    0);
    repeat (40) step(1'b0, 1'b0);
    chk("abort_no_done", int'(bus.done), 0);

    feed(16'b1101_0000, 8);
    repeat (9) step(1'b0, 1'b0);
    chk("abort_last_counting", int'(bus.counting), 1);
    abort_drv = 1'b1;
    step(1'b0, 1'b0);
    abort_drv = 1'b0;
    chk("abort_last_counting_off", int'(bus.counting), 0);
    chk("abort_last_done",         int'(bus.done),     0);
    step(1'b0, 1'b0);
    chk("abort_last_done_after", int'(bus.done), 0);
`endif

    // Random stream with sporadic ack (and abort when enabled)
    repeat (4000) begin
`ifdef PATTERN_DELAY_TIMER_ABORT_EN
      abort_drv = logic'($urandom_range(0, 63) == 0);
`endif
      step(1'($urandom_range(0, 1)), logic'($urandom_range(0, 7) == 0));
    end
`ifdef PATTERN_DELAY_TIMER_ABORT_EN
    abort_drv = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
